uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, number of byte entries; it shall be a power of two and at least 4.
REQ-002 The block SHALL have parameter AFULL, default 12, the fill level at or above which flow control deasserts; 1 <= AFULL <= DEPTH.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 The block SHALL have port in_valid, input, 1 bit: one-cycle strobe from the UART receiver marking a completed byte.
REQ-006 The block SHALL have port in_data, input, 8 bits: received byte, qualified by in_valid.
REQ-007 The block SHALL have port out_valid, output, 1 bit: head byte available (FIFO not empty).
REQ-008 The block SHALL have port out_data, output, 8 bits: head byte, qualified by out_valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer accepts the head byte.
REQ-010 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: current number of stored bytes.
REQ-011 The block SHALL have port rts, output, 1 bit: high = sender may transmit, low = sender must pause.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag, a byte was dropped.
REQ-013 The block SHALL have port ovf_clr, input, 1 bit: one-cycle strobe clearing overflow.

Function
REQ-014 The block SHALL store bytes in first-in first-out order in DEPTH entries addressed by write and read pointers that wrap from DEPTH-1 to 0.
REQ-015 A push SHALL occur on a clock edge where in_valid=1 and either count<DEPTH, or count=DEPTH and a pop occurs on the same edge.
REQ-016 A pop SHALL occur on a clock edge where out_valid=1 and out_ready=1.
REQ-017 out_valid SHALL equal (count!=0), and out_data SHALL present the head entry combinationally from registered state (show-ahead).
REQ-018 A byte pushed into an empty FIFO SHALL appear on out_data with out_valid=1 in the cycle after the push edge (latency 1 cycle).
REQ-019 On push only, count SHALL increment by 1; on pop only, decrement by 1; on simultaneous push and pop, count SHALL be unchanged and both pointers advance.
REQ-020 With count=0, in_valid=1 and out_ready=1 on the same edge, only the push SHALL occur (no pop of nonexistent data).
REQ-021 With count=DEPTH, in_valid=1 and no pop on the same edge, the byte SHALL be dropped, storage and count unchanged, and overflow set to 1 on that edge.
REQ-022 overflow SHALL remain 1 until an edge with ovf_clr=1 and no new drop; a drop and ovf_clr on the same edge SHALL leave overflow=1 (set wins).
REQ-023 rts SHALL equal (count < AFULL), derived from the registered count, so it updates in the cycle after the edge that changes count.
REQ-024 count SHALL never exceed DEPTH nor underflow below 0.
REQ-025 Pop with out_ready asserted continuously SHALL drain one byte per cycle; push SHALL accept one byte per cycle.

Reset
REQ-026 On an edge with rst_n=0, pointers and count SHALL become 0, overflow 0, out_valid 0 and rts 1, regardless of other inputs.
REQ-027 Reset mid-operation SHALL discard all stored bytes; storage RAM contents need not be cleared and out_data is don't-care while out_valid=0.
REQ-028 A push or pop presented on a reset edge SHALL be ignored.

Verification
REQ-029 Push 0x41,0x42,0x43 on consecutive cycles with out_ready=0 -> count=3, out_data=0x41; then out_ready=1 for 3 cycles -> out_data 0x41,0x42,0x43 in order, then out_valid=0, count=0.
REQ-030 Push 16 bytes 0x00..0x0F (DEPTH=16), then push 0xFF with out_ready=0 -> 0xFF dropped, overflow=1, count=16; drain yields 0x00..0x0F exactly.
REQ-031 Fill to 11 -> rts=1; push 12th -> rts=0 the next cycle; pop one -> rts=1 the next cycle.
REQ-032 Full FIFO, in_valid=1 and out_ready=1 on same edge -> count stays 16, 0xFF accepted, overflow unchanged; wrap pointers through 40 mixed push/pop cycles against a reference queue with no mismatch.
REQ-033 Empty FIFO, in_valid=1 with 0x5A and out_ready=1 same edge -> next cycle out_valid=1, out_data=0x5A, count=1.
REQ-034 Load 5 bytes with overflow=1, assert rst_n=0 for one edge -> count=0, out_valid=0, overflow=0, rts=1; then ovf_clr and drop on same edge -> overflow=1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between a UART receiver and its consumer.
// Show-ahead head output, RTS flow control from the fill level, and a sticky overflow flag.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AFULL = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     rts,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          ovf_r;

  logic empty_s;
  logic full_s;
  logic pop_s;
  logic push_s;
  logic drop_s;

  // Handshake decode; a full FIFO still accepts a byte when the head leaves on the same edge.
  always_comb begin
    empty_s = (count_r == (AW+1)'(0));
    full_s  = (count_r == DEPTH_C);
    pop_s   = !empty_s && out_ready;
    push_s  = in_valid && (!full_s || pop_s);
    drop_s  = in_valid && full_s && !pop_s;
  end

  // Byte storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (rst_n && push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // Pointer, fill-level and overflow state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
      // A drop on the clearing edge keeps the flag set.
      if (drop_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr) begin
        ovf_r <= 1'b0;
      end
    end
  end

  assign out_valid = !empty_s;
  assign out_data  = mem_r[rd_ptr_r];
  assign count     = count_r;
  assign rts       = (count_r < AFULL_C);
  assign overflow  = ovf_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=16, AFULL=12): vector table plus hand sequences
// for full/overflow, RTS threshold, pointer wrap against a reference queue, and reset.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic [4:0] count;
  logic       rts;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       r;
    logic       iv;
    logic [7:0] d;
    logic       rd;
    logic       clr;
    logic       ev;
    logic [7:0] ed;
    logic       cd;
    logic [4:0] ec;
    logic       er;
    logic       eo;
  } vec_t;

  vec_t tbl[11];

  uart_rx_fifo #(.DEPTH(16), .AFULL(12)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .rts(rts), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic iv, input logic [7:0] d,
                      input logic rd, input logic clr);
    rst_n = r; in_valid = iv; in_data = d; out_ready = rd; ovf_clr = clr;
    @(posedge clk);
    #1;
    rst_n = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic check(input string name, input logic ev, input logic [7:0] ed, input logic cd,
                       input logic [4:0] ec, input logic er, input logic eo);
    n_vec++;
    if (out_valid !== ev || (cd && out_data !== ed) || count !== ec ||
        rts !== er || overflow !== eo) begin
      n_err++;
      $display("FAIL %s: got valid=%b data=%02h count=%0d rts=%b ovf=%b, want valid=%b data=%02h count=%0d rts=%b ovf=%b",
               name, out_valid, out_data, count, rts, overflow, ev, ed, ec, er, eo);
    end
  endtask

  initial begin
    logic [7:0] q[$];
    logic       m_ovf;
    logic       iv, rd, pop, push;
    logic [7:0] d;

    //            r     iv    d      rd    clr   ev    ed     cd    ec     er    eo
    tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 8'h41, 1'b1, 5'd1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 8'h41, 1'b1, 5'd2, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 8'h43, 1'b0, 1'b0, 1'b1, 8'h41, 1'b1, 5'd3, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h41, 1'b1, 5'd3, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h42, 1'b1, 5'd2, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h43, 1'b1, 5'd1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 5'd1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 8'h77, 1'b1, 5'd1, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0};

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].r, tbl[i].iv, tbl[i].d, tbl[i].rd, tbl[i].clr);
      check($sformatf("table[%0d]", i), tbl[i].ev, tbl[i].ed, tbl[i].cd, tbl[i].ec, tbl[i].er, tbl[i].eo);
    end

    // Fill to DEPTH, then a dropped byte sets overflow.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
      check("fill", 1'b1, 8'h00, 1'b1, 5'(i + 1), (i + 1) < 12, 1'b0);
    end
    step(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    check("drop_full", 1'b1, 8'h00, 1'b1, 5'd16, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      check("drain", i < 15, 8'(i + 1), i < 15, 5'(15 - i), (15 - i) < 12, 1'b1);
    end
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_clr", 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0);

    // RTS threshold at 12 entries.
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    end
    check("rts_at_11", 1'b1, 8'h80, 1'b1, 5'd11, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'h8B, 1'b0, 1'b0);
    check("rts_at_12", 1'b1, 8'h80, 1'b1, 5'd12, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    check("rts_pop", 1'b1, 8'h81, 1'b1, 5'd11, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 8'(8'h8C + i), 1'b0, 1'b0);
    end
    check("refill", 1'b1, 8'h81, 1'b1, 5'd16, 1'b0, 1'b0);

    // Full with simultaneous push and pop: byte accepted, no overflow.
    step(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
    check("full_push_pop", 1'b1, 8'h82, 1'b1, 5'd16, 1'b0, 1'b0);

    // Mixed traffic through wrapped pointers against a reference queue.
    for (int v = 8'h82; v <= 8'h90; v++) q.push_back(8'(v));
    q.push_back(8'hFF);
    m_ovf = 1'b0;
    for (int i = 0; i < 40; i++) begin
      iv = (i % 3) != 0;
      rd = (i % 4) != 3;
      d  = 8'(i * 7 + 3);
      pop  = (q.size() != 0) && rd;
      push = iv && ((q.size() < 16) || pop);
      if (iv && !push) m_ovf = 1'b1;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
      step(1'b1, iv, d, rd, 1'b0);
      check($sformatf("mixed[%0d]", i), q.size() != 0, (q.size() != 0) ? q[0] : 8'h00,
            q.size() != 0, 5'(q.size()), q.size() < 12, m_ovf);
    end

    // Reset discards contents and overflow; push/pop on the reset edge are ignored.
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("reset2", 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    check("load5_ovf", 1'b1, 8'h2B, 1'b1, 5'd5, 1'b1, 1'b1);
    step(1'b0, 1'b1, 8'h99, 1'b1, 1'b0);
    check("reset_mid", 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("post_reset_idle", 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hEE, 1'b0, 1'b1);
    check("drop_and_clr", 1'b1, 8'h30, 1'b1, 5'd16, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_only", 1'b1, 8'h30, 1'b1, 5'd16, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
